// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
// Purpose: sequencer state encoding and default drain length.
// Ports: none (package).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_e;

  // EX, MEM and WB must empty after the halt leaves ID.
  localparam int unsigned DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard comparator
// Purpose: flags a decode instruction that reads the destination of a load in EX.
// Ports:
//   id_rs_i, id_rs_vld_i : decode source A and its read flag
//   id_rt_i, id_rt_vld_i : decode source B and its read flag
//   ex_write_reg_i       : destination register of the EX instruction
//   ex_regwrt_i          : EX instruction writes a register
//   ex_memrd_i           : EX instruction is a load
//   lu_o                 : load-use hazard present
module hazard_detect (
  input  logic [2:0] id_rs_i,
  input  logic       id_rs_vld_i,
  input  logic [2:0] id_rt_i,
  input  logic       id_rt_vld_i,
  input  logic [2:0] ex_write_reg_i,
  input  logic       ex_regwrt_i,
  input  logic       ex_memrd_i,
  output logic       lu_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_rs_vld_i && (id_rs_i == ex_write_reg_i);
  assign rt_hit = id_rt_vld_i && (id_rt_i == ex_write_reg_i);
  assign lu_o   = ex_memrd_i && ex_regwrt_i && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Purpose: drives hold enables and NOP flushes for PC, IF/ID, ID/EX, EX/MEM and
// MEM/WB; resolves memory freezes, taken branches, load-use bubbles and halt
// draining; keeps saturating stall/flush counters.
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   id_*                  : decode sources, their read flags, and halt marker
//   ex_*                  : EX destination/write/load info and taken-branch redirect
//   fetch_stall/mem_stall : instruction / data memory not ready
//   *_en, *_flush         : pipeline register enables and NOP insertion
//   halted                : pipeline fully drained after halt
//   stall_cnt, flush_cnt  : saturating performance counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_rs,
  input  logic             id_rs_vld,
  input  logic [2:0]       id_rt,
  input  logic             id_rt_vld,
  input  logic             id_halt,
  input  logic [2:0]       ex_write_reg,
  input  logic             ex_regwrt,
  input  logic             ex_memrd,
  input  logic             ex_branch_taken,
  input  logic             fetch_stall,
  input  logic             mem_stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES);

  pipe_state_e      state_q, state_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic lu;
  logic freeze;
  logic stall_inc;
  logic flush_inc;

  hazard_detect u_hazard_detect (
    .id_rs_i        (id_rs),
    .id_rs_vld_i    (id_rs_vld),
    .id_rt_i        (id_rt),
    .id_rt_vld_i    (id_rt_vld),
    .ex_write_reg_i (ex_write_reg),
    .ex_regwrt_i    (ex_regwrt),
    .ex_memrd_i     (ex_memrd),
    .lu_o           (lu)
  );

  assign freeze = fetch_stall || mem_stall;

  // State, drain counter and performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      drain_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Next state. A frozen cycle never advances the sequencer; in RUN a taken
  // branch or load-use bubble means the halt in ID is not yet committed.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      RUN: begin
        if (!freeze && !ex_branch_taken && !lu && id_halt) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (!freeze) begin
          if (drain_q <= DCW'(1)) begin
            state_d = HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DCW'(1);
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
        drain_d = '0;
      end
    endcase
  end

  // Outputs and counter increment requests.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    halted     = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    case (state_q)
      HALTED: begin
        halted = 1'b1;
      end
      DRAIN: begin
        // Front end stays parked; bubbles follow the halt down the pipe.
        stall_inc = 1'b1;
        if (!freeze) begin
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
        end
      end
      default: begin
        if (freeze) begin
          stall_inc = 1'b1;
        end else if (ex_branch_taken) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          flush_inc  = 1'b1;
        end else if (lu) begin
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          stall_inc  = 1'b1;
        end else begin
          // Normal flow, including the cycle the halt moves into ID/EX.
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
    if (flush_inc && (flush_q != {CNT_W{1'b1}})) flush_d = flush_q + CNT_W'(1);
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
  localparam logic [6:0] EN_NORM  = 7'b1101011;
  localparam logic [6:0] EN_FRZ   = 7'b0000000;
  localparam logic [6:0] EN_BR    = 7'b1111111;
  localparam logic [6:0] EN_LU    = 7'b0001111;
  localparam logic [6:0] EN_DRAIN = 7'b0001111;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs, id_rt, ex_write_reg;
  logic       id_rs_vld, id_rt_vld, id_halt;
  logic       ex_regwrt, ex_memrd, ex_branch_taken;
  logic       fetch_stall, mem_stall;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en, s_memwb_en, s_halted;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  logic [6:0] ens, ens_s;
  assign ens   = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};
  assign ens_s = {s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en, s_memwb_en};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt), .id_rt_vld(id_rt_vld),
    .id_halt(id_halt), .ex_write_reg(ex_write_reg), .ex_regwrt(ex_regwrt),
    .ex_memrd(ex_memrd), .ex_branch_taken(ex_branch_taken),
    .fetch_stall(fetch_stall), .mem_stall(mem_stall),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt), .id_rt_vld(id_rt_vld),
    .id_halt(id_halt), .ex_write_reg(ex_write_reg), .ex_regwrt(ex_regwrt),
    .ex_memrd(ex_memrd), .ex_branch_taken(ex_branch_taken),
    .fetch_stall(fetch_stall), .mem_stall(mem_stall),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
    .idex_flush(s_idex_flush), .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
    .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = 3'd0; id_rs_vld = 1'b0; id_rt = 3'd0; id_rt_vld = 1'b0; id_halt = 1'b0;
    ex_write_reg = 3'd0; ex_regwrt = 1'b0; ex_memrd = 1'b0; ex_branch_taken = 1'b0;
    fetch_stall = 1'b0; mem_stall = 1'b0;
  endtask

  // Check combinational enables mid-cycle, then advance to the next negedge.
  task automatic cyc(input string tag, input logic [6:0] exp_en);
    #1;
    check_val(tag, {25'd0, ens}, {25'd0, exp_en});
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
    check_val("rst_stall", {16'd0, stall_cnt}, 32'd0);
    check_val("rst_flush", {16'd0, flush_cnt}, 32'd0);
    rst = 1'b1;
    cyc("rst_en", EN_NORM);

    // Load-use on rs: exactly one bubble
    ex_memrd = 1'b1; ex_regwrt = 1'b1; ex_write_reg = 3'd3; id_rs = 3'd3; id_rs_vld = 1'b1;
    cyc("lu_rs", EN_LU);
    check_val("lu_rs_stall", {16'd0, stall_cnt}, 32'd1);
    ex_memrd = 1'b0; id_rs_vld = 1'b0;
    cyc("lu_after", EN_NORM);
    check_val("lu_after_stall", {16'd0, stall_cnt}, 32'd1);

    // False hazards
    ex_memrd = 1'b1; id_rs = 3'd3; id_rs_vld = 1'b0; id_rt = 3'd3; id_rt_vld = 1'b0;
    cyc("false_vld", EN_NORM);
    id_rs_vld = 1'b1; ex_memrd = 1'b0;
    cyc("false_noload", EN_NORM);
    ex_memrd = 1'b1; ex_regwrt = 1'b0;
    cyc("false_nowrite", EN_NORM);
    check_val("false_stall", {16'd0, stall_cnt}, 32'd1);

    // Load-use on rt
    ex_regwrt = 1'b1; id_rs = 3'd5; id_rs_vld = 1'b1; id_rt = 3'd3; id_rt_vld = 1'b1;
    cyc("lu_rt", EN_LU);
    check_val("lu_rt_stall", {16'd0, stall_cnt}, 32'd2);
    id_rt = 3'd4;
    cyc("false_regmiss", EN_NORM);
    check_val("regmiss_stall", {16'd0, stall_cnt}, 32'd2);

    // Branch overrides load-use
    id_rt = 3'd3; ex_branch_taken = 1'b1;
    cyc("br_lu", EN_BR);
    check_val("br_lu_flush", {16'd0, flush_cnt}, 32'd1);
    check_val("br_lu_stall", {16'd0, stall_cnt}, 32'd2);

    // Memory freeze during load-use, then the single bubble
    ex_branch_taken = 1'b0; mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) cyc("freeze", EN_FRZ);
    check_val("freeze_stall", {16'd0, stall_cnt}, 32'd6);
    mem_stall = 1'b0;
    cyc("freeze_lu", EN_LU);
    check_val("freeze_lu_stall", {16'd0, stall_cnt}, 32'd7);
    idle(); fetch_stall = 1'b1;
    cyc("fetch_freeze", EN_FRZ);
    check_val("fetch_stall_cnt", {16'd0, stall_cnt}, 32'd8);
    fetch_stall = 1'b0;

    // Plain halt drain
    id_halt = 1'b1;
    cyc("halt_entry", EN_NORM);
    id_halt = 1'b0;
    check_val("halt_entry_stall", {16'd0, stall_cnt}, 32'd8);
    for (int i = 0; i < 3; i++) begin
      cyc("drain", EN_DRAIN);
      check_val("drain_halted", {31'd0, halted}, (i == 2) ? 32'd1 : 32'd0);
    end
    check_val("drain_stall", {16'd0, stall_cnt}, 32'd11);
    mem_stall = 1'b1; ex_branch_taken = 1'b1;
    cyc("halted_en", EN_FRZ);
    check_val("halted_stall", {16'd0, stall_cnt}, 32'd11);
    check_val("halted_flush", {16'd0, flush_cnt}, 32'd1);
    check_val("halted_hold", {31'd0, halted}, 32'd1);
    check_val("sat_mirror_stall", {28'd0, s_stall_cnt}, 32'd11);
    idle();

    // Reset out of HALTED
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_val("rst2_halted", {31'd0, halted}, 32'd0);
    check_val("rst2_stall", {16'd0, stall_cnt}, 32'd0);
    check_val("rst2_flush", {16'd0, flush_cnt}, 32'd0);
    cyc("rst2_en", EN_NORM);

    // Branch and halt together: halt is wrong-path
    id_halt = 1'b1; ex_branch_taken = 1'b1;
    cyc("br_halt", EN_BR);
    idle();
    cyc("br_halt_nodrain", EN_NORM);
    check_val("br_halt_halted", {31'd0, halted}, 32'd0);
    check_val("br_halt_flush", {16'd0, flush_cnt}, 32'd1);
    check_val("br_halt_stall", {16'd0, stall_cnt}, 32'd0);

    // Halt drain with a 2-cycle fetch freeze inside it
    id_halt = 1'b1;
    cyc("halt2_entry", EN_NORM);
    id_halt = 1'b0;
    cyc("halt2_d1", EN_DRAIN);
    fetch_stall = 1'b1;
    cyc("halt2_f1", EN_FRZ);
    cyc("halt2_f2", EN_FRZ);
    fetch_stall = 1'b0;
    cyc("halt2_d2", EN_DRAIN);
    check_val("halt2_not_yet", {31'd0, halted}, 32'd0);
    cyc("halt2_d3", EN_DRAIN);
    check_val("halt2_halted", {31'd0, halted}, 32'd1);
    check_val("halt2_stall", {16'd0, stall_cnt}, 32'd5);

    // Saturation on the narrow-counter instance
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_stall = 1'b1;
    for (int i = 0; i < 20; i++) cyc("sat_freeze", EN_FRZ);
    mem_stall = 1'b0;
    check_val("sat_wide_stall", {16'd0, stall_cnt}, 32'd20);
    check_val("sat_narrow_stall", {28'd0, s_stall_cnt}, 32'd15);
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 17; i++) cyc("sat_branch", EN_BR);
    ex_branch_taken = 1'b0;
    check_val("sat_wide_flush", {16'd0, flush_cnt}, 32'd17);
    check_val("sat_narrow_flush", {28'd0, s_flush_cnt}, 32'd15);
    id_halt = 1'b1;
    cyc("sat_halt", EN_NORM);
    id_halt = 1'b0;
    for (int i = 0; i < 3; i++) cyc("sat_drain", EN_DRAIN);
    check_val("sat_halted", {31'd0, s_halted}, 32'd1);
    check_val("sat_drain_wide", {16'd0, stall_cnt}, 32'd23);
    check_val("sat_drain_narrow", {28'd0, s_stall_cnt}, 32'd15);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_val("sat_rst_stall", {28'd0, s_stall_cnt}, 32'd0);
    check_val("sat_rst_flush", {28'd0, s_flush_cnt}, 32'd0);
    check_val("sat_rst_halted", {31'd0, s_halted}, 32'd0);
    #1;
    check_val("sat_rst_en", {25'd0, ens_s}, {25'd0, EN_NORM});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
